// File: rtl/french_collision_ctrl.sv
// Purpose : per-frame frog/French-enemy bounding-box collision test with lives, invulnerability and game-over.
// Latency : startOfFrame in cycle k -> eval in k+2 -> hit/frog_reset/lives/state visible in k+3.
// Backpr. : none; a new startOfFrame overwrites in-flight coordinates, restart flushes the pipeline.
module french_collision_ctrl #(
  parameter int FRENCH_W      = 32,
  parameter int FRENCH_H      = 32,
  parameter int FROG_W        = 32,
  parameter int FROG_H        = 32,
  parameter int LIVES         = 3,
  parameter int INVULN_FRAMES = 60
) (
  input  logic        CLK,
  input  logic        RESETn,
  input  logic        startOfFrame,
  input  logic [10:0] frenchX,
  input  logic [10:0] frenchY,
  input  logic [10:0] frogX,
  input  logic [10:0] frogY,
  input  logic        restart,
  output logic        hit,
  output logic        frog_reset,
  output logic [2:0]  lives,
  output logic        invulnerable,
  output logic        game_over
);

  typedef enum logic [1:0] {
    ST_ARMED     = 2'd0,
    ST_INVULN    = 2'd1,
    ST_GAME_OVER = 2'd2
  } state_t;

  // Box extents minus one, widened so coordinate + extent never wraps.
  localparam logic [11:0] FRENCH_W_M1 = 12'(FRENCH_W - 1);
  localparam logic [11:0] FRENCH_H_M1 = 12'(FRENCH_H - 1);
  localparam logic [11:0] FROG_W_M1   = 12'(FROG_W - 1);
  localparam logic [11:0] FROG_H_M1   = 12'(FROG_H - 1);
  localparam logic [2:0]  LIVES_INIT  = 3'(LIVES);
  localparam logic [7:0]  INV_INIT    = 8'(INVULN_FRAMES);

  // S0 latches
  logic [10:0] french_x_q, french_x_d;
  logic [10:0] french_y_q, french_y_d;
  logic [10:0] frog_x_q, frog_x_d;
  logic [10:0] frog_y_q, frog_y_d;
  logic        eval_pending_q, eval_pending_d;

  // S1 result
  logic        overlap_q, overlap_d;
  logic        eval_valid_q, eval_valid_d;
  logic        overlap_now;

  // S2 state
  state_t      state_q, state_d;
  logic [2:0]  lives_q, lives_d;
  logic [7:0]  inv_cnt_q, inv_cnt_d;
  logic        hit_q, hit_d;
  logic        frog_reset_q;
  logic        invulnerable_q;
  logic        game_over_q;

  // S0: capture coordinates on every frame strobe; restart cancels the pending evaluation.
  always_comb begin
    french_x_d     = french_x_q;
    french_y_d     = french_y_q;
    frog_x_d       = frog_x_q;
    frog_y_d       = frog_y_q;
    eval_pending_d = startOfFrame && !restart;
    if (startOfFrame) begin
      french_x_d = frenchX;
      french_y_d = frenchY;
      frog_x_d   = frogX;
      frog_y_d   = frogY;
    end
  end

  // S1: inclusive AABB overlap on 12-bit zero-extended coordinates (shared edge pixels collide).
  always_comb begin
    logic [11:0] fx, fy, gx, gy;
    fx = {1'b0, french_x_q};
    fy = {1'b0, french_y_q};
    gx = {1'b0, frog_x_q};
    gy = {1'b0, frog_y_q};
    overlap_now = (fx <= gx + FROG_W_M1)   &&
                  (gx <= fx + FRENCH_W_M1) &&
                  (fy <= gy + FROG_H_M1)   &&
                  (gy <= fy + FRENCH_H_M1);
  end

  // S1: register the overlap result alongside a one-cycle valid strobe.
  always_comb begin
    overlap_d    = eval_pending_q ? overlap_now : overlap_q;
    eval_valid_d = eval_pending_q && !restart;
  end

  // S2: life/invulnerability state machine; restart outranks any same-cycle evaluation.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    inv_cnt_d = inv_cnt_q;
    hit_d     = 1'b0;
    if (restart) begin
      state_d   = ST_ARMED;
      lives_d   = LIVES_INIT;
      inv_cnt_d = 8'd0;
    end else if (eval_valid_q) begin
      case (state_q)
        ST_ARMED: begin
          if (overlap_q) begin
            hit_d = 1'b1;
            if (lives_q <= 3'd1) begin
              lives_d = 3'd0;
              state_d = ST_GAME_OVER;
            end else begin
              lives_d = lives_q - 3'd1;
              if (INV_INIT != 8'd0) begin
                state_d   = ST_INVULN;
                inv_cnt_d = INV_INIT;
              end
            end
          end
        end
        ST_INVULN: begin
          // Overlaps are ignored; each evaluated frame burns one frame of protection.
          if (inv_cnt_q <= 8'd1) begin
            inv_cnt_d = 8'd0;
            state_d   = ST_ARMED;
          end else begin
            inv_cnt_d = inv_cnt_q - 8'd1;
          end
        end
        ST_GAME_OVER: begin
          lives_d = 3'd0;
        end
        default: begin
          state_d = ST_ARMED;
        end
      endcase
    end
  end

  // Pipeline registers and FSM state with registered output decodes.
  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      french_x_q     <= 11'd0;
      french_y_q     <= 11'd0;
      frog_x_q       <= 11'd0;
      frog_y_q       <= 11'd0;
      eval_pending_q <= 1'b0;
      overlap_q      <= 1'b0;
      eval_valid_q   <= 1'b0;
      state_q        <= ST_ARMED;
      lives_q        <= LIVES_INIT;
      inv_cnt_q      <= 8'd0;
      hit_q          <= 1'b0;
      frog_reset_q   <= 1'b0;
      invulnerable_q <= 1'b0;
      game_over_q    <= 1'b0;
    end else begin
      french_x_q     <= french_x_d;
      french_y_q     <= french_y_d;
      frog_x_q       <= frog_x_d;
      frog_y_q       <= frog_y_d;
      eval_pending_q <= eval_pending_d;
      overlap_q      <= overlap_d;
      eval_valid_q   <= eval_valid_d;
      state_q        <= state_d;
      lives_q        <= lives_d;
      inv_cnt_q      <= inv_cnt_d;
      hit_q          <= hit_d;
      frog_reset_q   <= hit_d;
      invulnerable_q <= (state_d == ST_INVULN);
      game_over_q    <= (state_d == ST_GAME_OVER);
    end
  end

  assign hit          = hit_q;
  assign frog_reset   = frog_reset_q;
  assign lives        = lives_q;
  assign invulnerable = invulnerable_q;
  assign game_over    = game_over_q;

endmodule

// File: doc/french_collision_ctrl.md
# french_collision_ctrl

Collision and life-management controller that consumes the French enemy position produced by the enemy movement stage, together with the frog position. Once per video frame it performs an axis-aligned bounding-box overlap test. On a hit it emits pulses that send the frog back to its start position, decrements the life counter, runs an invulnerability window counted in frames, and latches game-over until a restart. It sits between the object movement stages and the game-state/display logic.

## Interface
Parameters:
- FRENCH_W, 32, enemy bounding-box width in pixels
- FRENCH_H, 32, enemy bounding-box height in pixels
- FROG_W, 32, frog bounding-box width in pixels
- FROG_H, 32, frog bounding-box height in pixels
- LIVES, 3, lives after reset or restart (1..7)
- INVULN_FRAMES, 60, frames of invulnerability after a non-fatal hit (0..255)

Ports:
- CLK  in  1  system clock; the block uses this single clock
- RESETn  in  1  asynchronous, active-low reset
- startOfFrame  in  1  one-cycle pulse, once per frame
- frenchX  in  11  enemy top-left X (enemy movement stage ObjectStartX)
- frenchY  in  11  enemy top-left Y (enemy movement stage ObjectStartY)
- frogX  in  11  frog top-left X
- frogY  in  11  frog top-left Y
- restart  in  1  one-cycle pulse that starts a new game
- hit  out  1  one-cycle pulse on each counted collision
- frog_reset  out  1  one-cycle pulse, coincident with hit
- lives  out  3  remaining lives
- invulnerable  out  1  high while in state INVULN
- game_over  out  1  high while in state GAME_OVER

## Operation
- The pipeline has three stages, all registered:
  - S0: on startOfFrame, latch all four coordinates and set eval_pending.
  - S1: compute the overlap from the latched values, register it as overlap_q, and set eval_valid for one cycle.
  - S2: the FSM consumes eval_valid and overlap_q.
- Overlap test, using 12-bit zero-extended arithmetic so the sums cannot wrap. All four conditions must hold:
  - frenchX <= frogX+FROG_W-1
  - frogX <= frenchX+FRENCH_W-1
  - frenchY <= frogY+FROG_H-1
  - frogY <= frenchY+FRENCH_H-1
- The boxes are inclusive, so shared edge pixels count as an overlap.
- FSM states are ARMED, INVULN and GAME_OVER.
- ARMED, on eval_valid with overlap_q=1:
  - hit and frog_reset pulse, and lives decrements.
  - If lives was 1, lives becomes 0 and the state goes to GAME_OVER.
  - Otherwise, if INVULN_FRAMES=0, the state stays ARMED.
  - Otherwise the state goes to INVULN and inv_cnt is loaded with INVULN_FRAMES (8-bit counter).
- ARMED, on eval_valid with overlap_q=0: no action.
- INVULN:
  - Overlaps are ignored.
  - Each eval_valid decrements inv_cnt. When inv_cnt goes 1→0, the state returns to ARMED.
  - The first evaluation that can hit again is therefore the (INVULN_FRAMES+1)th frame after the hit.
- GAME_OVER: all evaluations are ignored; lives stays 0.
- restart, in any state:
  - Next state is ARMED, lives is reloaded to LIVES, and inv_cnt clears.
  - eval_pending and eval_valid clear, flushing any in-flight evaluation.
  - restart has priority over a hit in the same cycle; no hit pulse is produced.
- A startOfFrame that arrives while an evaluation is in flight overwrites the S0 latches. Each eval_valid uses the most recently latched coordinates.

## Timing
- If startOfFrame is high in cycle k, eval_valid is high in cycle k+2, and hit/frog_reset/lives/state update in cycle k+3.
- hit and frog_reset are high for exactly one cycle per counted collision.
- invulnerable and game_over are registered decodes of the state and change in the same cycle as lives.
- Async reset values:
  - hit=0, frog_reset=0
  - lives=LIVES
  - invulnerable=0, game_over=0
  - state ARMED
  - inv_cnt=0
  - pipeline flags cleared
- Reset is effective mid-operation in any state. The first evaluation after reset needs a new startOfFrame.
- restart in cycle j: outputs show the restarted values in cycle j+1.

## Test plan
- Reset: assert RESETn=0 mid-INVULN, then release → lives=3, invulnerable=0, game_over=0, hit=0. No hit until a new startOfFrame is seen with overlap.
- Basic hit: french=(100,100), frog=(120,110), startOfFrame in cycle k → hit and frog_reset high only in cycle k+3. In that cycle lives becomes 2 and invulnerable becomes 1.
- Boundary: french=(100,100), frogY=100, frogX=132 → no hit. frogX=131 → hit. Repeat on the Y axis, and with frenchX=0, frogX=2016 (no wrap, no hit).
- Invulnerability: keep the boxes overlapping on every frame after a hit → no hit for 60 frames. invulnerable drops after the 60th evaluation, and the 61st frame hits, giving lives=1.
- Game over: three counted hits → lives=0, game_over=1, further overlaps give no pulse. restart → lives=3, game_over=0, state ARMED.
- Restart priority: restart in the same cycle an overlapping eval_valid would produce a hit → no hit pulse and lives=3. Also check an INVULN_FRAMES=0 build: consecutive overlapping frames hit on every frame.
